// File: rtl/axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter
//
// Shares one AXI read path (AR + R channels) among N_MST upstream requesters.
// Round-robin arbitration with a single burst in flight: a requester keeps the
// grant from its AR until the R beat carrying rlast has been accepted. Write
// channels are not handled and are tied off on both sides.
//
// Optional feature (macro AXI_RD_ARB_PERF_EN):
//   Adds output gnt_cnt_o[N_MST] of 32-bit saturating counters, one per
//   requester, incremented on every completed burst of that requester.
//
// Parameters:
//   N_MST          number of requesters, 2..8
//
// Ports:
//   clk            clock, all state on the rising edge
//   arst           asynchronous active-high reset
//   slave_mosi_i   requester buses; only ar* and rready are used
//   slave_miso_o   requester responses; arready and r* driven, rest 0
//   master_mosi_o  shared downstream bus; aw*, w* and bready held at 0
//   master_miso_i  downstream responses; only arready and r* are used
//   gnt_cnt_o      per-requester completed-burst counters (perf build only)
// ---------------------------------------------------------------------------

package axi_rd_arbiter_pkg;

    localparam int unsigned IdW   = 4;
    localparam int unsigned AddrW = 32;
    localparam int unsigned DataW = 32;

    typedef struct packed {
        logic [IdW-1:0]     awid;
        logic [AddrW-1:0]   awaddr;
        logic [7:0]         awlen;
        logic [2:0]         awsize;
        logic [1:0]         awburst;
        logic               awvalid;
        logic [DataW-1:0]   wdata;
        logic [DataW/8-1:0] wstrb;
        logic               wlast;
        logic               wvalid;
        logic               bready;
        logic [IdW-1:0]     arid;
        logic [AddrW-1:0]   araddr;
        logic [7:0]         arlen;
        logic [2:0]         arsize;
        logic [1:0]         arburst;
        logic               arvalid;
        logic               rready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic               awready;
        logic               wready;
        logic [IdW-1:0]     bid;
        logic [1:0]         bresp;
        logic               bvalid;
        logic               arready;
        logic [IdW-1:0]     rid;
        logic [DataW-1:0]   rdata;
        logic [1:0]         rresp;
        logic               rlast;
        logic               rvalid;
    } s_axi_miso_t;

endpackage

module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int unsigned N_MST = 2
) (
    input  logic                    clk,
    input  logic                    arst,
    input  s_axi_mosi_t [N_MST-1:0] slave_mosi_i,
    output s_axi_miso_t [N_MST-1:0] slave_miso_o,
    output s_axi_mosi_t             master_mosi_o,
    input  s_axi_miso_t             master_miso_i
`ifdef AXI_RD_ARB_PERF_EN
    ,
    output logic [31:0]             gnt_cnt_o [N_MST]
`endif
);

    localparam int unsigned GW = (N_MST > 1) ? $clog2(N_MST) : 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAddr = 2'd1,
        StData = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [GW-1:0] gnt_q, gnt_d;
    logic [GW-1:0] rr_q, rr_d;
    logic [GW-1:0] winner;
    logic          any_req;
    logic          r_last_hs;
    s_axi_mosi_t   gnt_mosi;
    logic          unused_in;

    // (base + off) mod N_MST for base, off < N_MST; one spare bit holds the carry.
    function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] base,
                                               input int unsigned off);
        logic [GW:0] sum;
        sum = {1'b0, base} + (GW+1)'(off);
        if (sum >= (GW+1)'(N_MST)) begin
            sum = sum - (GW+1)'(N_MST);
        end
        return sum[GW-1:0];
    endfunction

    // Bus of the currently granted requester.
    assign gnt_mosi = slave_mosi_i[gnt_q];

    // Final R handshake of the in-flight burst.
    assign r_last_hs = (state_q == StData) & master_miso_i.rvalid & gnt_mosi.rready &
                       master_miso_i.rlast;

    // Write-channel inputs and unused response fields are intentionally ignored.
    assign unused_in = ^{slave_mosi_i, master_miso_i};

    // Round-robin pick: first requester with arvalid at or after rr_q.
    always_comb begin
        winner  = rr_q;
        any_req = 1'b0;
        for (int unsigned off = 0; off < N_MST; off++) begin
            if (!any_req && slave_mosi_i[wrap_add(rr_q, off)].arvalid) begin
                any_req = 1'b1;
                winner  = wrap_add(rr_q, off);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    gnt_d   = winner;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                // A withdrawn request releases the grant without moving the pointer.
                if (!gnt_mosi.arvalid) begin
                    state_d = StIdle;
                end else if (master_miso_i.arready) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (r_last_hs) begin
                    state_d = StIdle;
                    rr_d    = (gnt_q == GW'(N_MST - 1)) ? '0 : gnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output routing; everything not explicitly driven stays 0.
    always_comb begin
        master_mosi_o = '0;
        slave_miso_o  = '0;
        unique case (state_q)
            StAddr: begin
                master_mosi_o.arid          = gnt_mosi.arid;
                master_mosi_o.araddr        = gnt_mosi.araddr;
                master_mosi_o.arlen         = gnt_mosi.arlen;
                master_mosi_o.arsize        = gnt_mosi.arsize;
                master_mosi_o.arburst       = gnt_mosi.arburst;
                master_mosi_o.arvalid       = gnt_mosi.arvalid;
                slave_miso_o[gnt_q].arready = master_miso_i.arready;
            end
            StData: begin
                master_mosi_o.rready       = gnt_mosi.rready;
                slave_miso_o[gnt_q].rid    = master_miso_i.rid;
                slave_miso_o[gnt_q].rdata  = master_miso_i.rdata;
                slave_miso_o[gnt_q].rresp  = master_miso_i.rresp;
                slave_miso_o[gnt_q].rlast  = master_miso_i.rlast;
                slave_miso_o[gnt_q].rvalid = master_miso_i.rvalid;
            end
            default: begin
            end
        endcase
    end

`ifdef AXI_RD_ARB_PERF_EN
    logic [31:0] cnt_q [N_MST];

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < int'(N_MST); i++) begin
                cnt_q[i] <= '0;
            end
        end else if (r_last_hs && (cnt_q[gnt_q] != 32'hFFFF_FFFF)) begin
            cnt_q[gnt_q] <= cnt_q[gnt_q] + 32'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(N_MST); i++) begin
            gnt_cnt_o[i] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_arbiter
//
// Directed and randomized stimulus for axi_rd_arbiter (N_MST = 3). Expected
// grants come from a round-robin model over a pending-request table; R beats
// are checked against the values the bench drives downstream.
// ---------------------------------------------------------------------------
module tb_axi_rd_arbiter;
    import axi_rd_arbiter_pkg::*;

    localparam int unsigned N = 3;

    logic                clk  = 1'b0;
    logic                arst = 1'b1;
    s_axi_mosi_t [N-1:0] smosi;
    s_axi_miso_t [N-1:0] smiso;
    s_axi_mosi_t         mmosi;
    s_axi_miso_t         mmiso;
`ifdef AXI_RD_ARB_PERF_EN
    logic [31:0]         gnt_cnt [N];
`endif

    axi_rd_arbiter #(
        .N_MST(N)
    ) dut (
        .clk          (clk),
        .arst         (arst),
        .slave_mosi_i (smosi),
        .slave_miso_o (smiso),
        .master_mosi_o(mmosi),
        .master_miso_i(mmiso)
`ifdef AXI_RD_ARB_PERF_EN
        ,
        .gnt_cnt_o    (gnt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         rr_m  = 0;
    bit         pend     [N];
    logic [3:0] req_id   [N];
    logic [31:0] req_addr[N];
    logic [7:0] req_len  [N];
    int         cnt_m    [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic post(input int m, input logic [3:0] id, input logic [31:0] addr,
                        input logic [7:0] len);
        pend[m]           = 1'b1;
        req_id[m]         = id;
        req_addr[m]       = addr;
        req_len[m]        = len;
        smosi[m].arid     = id;
        smosi[m].araddr   = addr;
        smosi[m].arlen    = len;
        smosi[m].arsize   = 3'd2;
        smosi[m].arburst  = 2'd1;
        smosi[m].arvalid  = 1'b1;
    endtask

    task automatic post_rand(input int m);
        post(m, 4'($urandom), 32'($urandom) & 32'hFFFF_FFFC, 8'($urandom_range(0, 7)));
    endtask

    // Round-robin reference: first pending requester at or after rr_m.
    function automatic int pick();
        for (int off = 0; off < int'(N); off++) begin
            if (pend[(rr_m + off) % int'(N)]) return (rr_m + off) % int'(N);
        end
        return -1;
    endfunction

    function automatic bit any_pend();
        for (int i = 0; i < int'(N); i++) if (pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Called in the negedge phase; leaves reset released one cycle later.
    task automatic do_reset();
        arst  = 1'b1;
        smosi = '0;
        mmiso = '0;
        for (int i = 0; i < int'(N); i++) pend[i] = 1'b0;
        #1;
        chk("rst_master_mosi_zero", 64'(mmosi != '0), 64'(0));
        for (int i = 0; i < int'(N); i++) begin
            chk($sformatf("rst_slave_miso_zero[%0d]", i), 64'(smiso[i] != '0), 64'(0));
        end
        @(negedge clk);
        arst = 1'b0;
        rr_m = 0;
        for (int i = 0; i < int'(N); i++) cnt_m[i] = 0;
    endtask

    // R beat presented while idle must be backpressured and not forwarded.
    task automatic stray_r();
        mmiso.rvalid = 1'b1;
        mmiso.rlast  = 1'b1;
        mmiso.rdata  = $urandom;
        #1;
        chk("stray_rready", 64'(mmosi.rready), 64'(0));
        for (int i = 0; i < int'(N); i++) begin
            chk($sformatf("stray_rvalid[%0d]", i), 64'(smiso[i].rvalid), 64'(0));
        end
        @(negedge clk);
        mmiso = '0;
    endtask

    // Serves the model's next winner: arbitration cycle, AR with 'stall' cycles of
    // arready low, then R beats with random gaps/backpressure. abort_after >= 0
    // asserts reset once that many beats have been accepted.
    task automatic serve(input int stall, input int abort_after);
        int          g;
        int          beats;
        int          cyc;
        logic        rv;
        logic        rdy;
        logic        last;
        logic [1:0]  resp;
        logic [31:0] d;
        bit          hold;
        g = pick();
        if (g < 0) return;
        #1;
        chk("idle_arvalid", 64'(mmosi.arvalid), 64'(0));
        for (int i = 0; i < int'(N); i++) begin
            chk($sformatf("idle_arready[%0d]", i), 64'(smiso[i].arready), 64'(0));
        end
        @(negedge clk);
        for (int s = 0; s <= stall; s++) begin
            mmiso.arready = (s == stall);
            mmiso.rvalid  = (s != stall) && ($urandom_range(0, 1) == 1);
            #1;
            chk("addr_arvalid", 64'(mmosi.arvalid), 64'(1));
            chk("addr_araddr", 64'(mmosi.araddr), 64'(req_addr[g]));
            chk("addr_arid_len", 64'({mmosi.arid, mmosi.arlen}), 64'({req_id[g], req_len[g]}));
            chk($sformatf("addr_arready_gnt[%0d]", g), 64'(smiso[g].arready),
                64'(mmiso.arready));
            for (int i = 0; i < int'(N); i++) begin
                if (i != g) chk($sformatf("addr_arready[%0d]", i), 64'(smiso[i].arready),
                                64'(0));
            end
            chk("addr_rready", 64'(mmosi.rready), 64'(0));
            chk("addr_rvalid", 64'(smiso[g].rvalid), 64'(0));
            @(negedge clk);
        end
        mmiso            = '0;
        smosi[g].arvalid = 1'b0;
        pend[g]          = 1'b0;
        beats = 0;
        cyc   = 0;
        hold  = 1'b0;
        rv    = 1'b0;
        d     = '0;
        resp  = '0;
        while (beats <= int'(req_len[g]) && cyc < 400) begin
            // A presented beat stays stable until accepted.
            if (!hold) begin
                rv   = ($urandom_range(0, 3) != 0);
                d    = $urandom;
                resp = 2'($urandom_range(0, 3));
            end
            rdy  = ($urandom_range(0, 2) != 0);
            last = (beats == int'(req_len[g]));
            mmiso.rvalid     = rv;
            mmiso.rdata      = d;
            mmiso.rid        = req_id[g];
            mmiso.rresp      = resp;
            mmiso.rlast      = last;
            smosi[g].rready  = rdy;
            #1;
            chk($sformatf("r_rvalid[%0d]", g), 64'(smiso[g].rvalid), 64'(rv));
            if (rv) begin
                chk("r_rdata", 64'(smiso[g].rdata), 64'(d));
                chk("r_ctrl", 64'({smiso[g].rid, smiso[g].rresp, smiso[g].rlast}),
                    64'({req_id[g], resp, last}));
            end
            for (int i = 0; i < int'(N); i++) begin
                if (i != g) chk($sformatf("r_rvalid_other[%0d]", i), 64'(smiso[i].rvalid),
                                64'(0));
            end
            chk("r_rready", 64'(mmosi.rready), 64'(rdy));
            chk("r_arvalid", 64'(mmosi.arvalid), 64'(0));
            chk("r_tieoff", 64'({mmosi.awvalid, mmosi.wvalid, mmosi.bready, smiso[g].awready,
                                 smiso[g].wready, smiso[g].bvalid}), 64'(0));
            hold = rv && !rdy;
            if (rv && rdy) beats++;
            cyc++;
            @(negedge clk);
            if (abort_after >= 0 && beats == abort_after) begin
                do_reset();
                return;
            end
        end
        mmiso           = '0;
        smosi[g].rready = 1'b0;
        rr_m            = (g + 1) % int'(N);
        cnt_m[g]++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        smosi = '0;
        mmiso = '0;
        for (int i = 0; i < int'(N); i++) begin
            pend[i]  = 1'b0;
            cnt_m[i] = 0;
        end
        @(negedge clk);
        do_reset();

        // Single request: m0 id=3 addr=0x1000 len=3.
        post(0, 4'd3, 32'h0000_1000, 8'd3);
        serve(0, -1);

        // Stray R while idle.
        stray_r();

        // Contention right after reset, then again after both were served.
        do_reset();
        post(0, 4'd1, 32'h0000_2000, 8'd1);
        post(1, 4'd2, 32'h0000_3000, 8'd2);
        serve(0, -1);
        serve(0, -1);
        post(0, 4'd4, 32'h0000_4000, 8'd0);
        post(1, 4'd5, 32'h0000_5000, 8'd0);
        serve(0, -1);
        serve(0, -1);

        // AR backpressure for 5 cycles.
        post(0, 4'd6, 32'h0000_6000, 8'd3);
        serve(5, -1);

        // Granted requester withdraws arvalid before the handshake.
        do_reset();
        post(0, 4'd7, 32'h0000_7000, 8'd0);
        serve(0, -1);
        post(1, 4'd8, 32'h0000_8000, 8'd0);
        #1;
        chk("drop_idle_arvalid", 64'(mmosi.arvalid), 64'(0));
        @(negedge clk);
        mmiso.arready = 1'b0;
        #1;
        chk("drop_addr_arvalid", 64'(mmosi.arvalid), 64'(1));
        chk("drop_addr_arready", 64'(smiso[1].arready), 64'(0));
        @(negedge clk);
        smosi[1].arvalid = 1'b0;
        pend[1]          = 1'b0;
        #1;
        chk("drop_follow_arvalid", 64'(mmosi.arvalid), 64'(0));
        @(negedge clk);
        post(0, 4'd9, 32'h0000_9000, 8'd1);
        post(1, 4'd10, 32'h0000_A000, 8'd1);
        serve(1, -1);
        serve(0, -1);

        // Reset mid-DATA after 2 of 4 beats, with the pointer away from 0.
        post(0, 4'd11, 32'h0000_B000, 8'd0);
        serve(0, -1);
        post(0, 4'd12, 32'h0000_C000, 8'd3);
        serve(0, 2);
        post(0, 4'd13, 32'h0000_D000, 8'd1);
        post(1, 4'd14, 32'h0000_E000, 8'd1);
        serve(0, -1);
        serve(0, -1);

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            if (!any_pend() && $urandom_range(0, 3) == 0) stray_r();
            for (int m = 0; m < int'(N); m++) begin
                if (!pend[m] && $urandom_range(0, 1) == 1) post_rand(m);
            end
            if (!any_pend()) post_rand($urandom_range(0, N - 1));
            serve($urandom_range(0, 3), -1);
        end
        while (any_pend()) serve(0, -1);

`ifdef AXI_RD_ARB_PERF_EN
        for (int i = 0; i < int'(N); i++) begin
            chk($sformatf("gnt_cnt[%0d]", i), 64'(gnt_cnt[i]), 64'(cnt_m[i]));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
